// File: rtl/recebe_movimentos_param.sv
// Movement-list receiver. It requests a movement sequence over the serial
// link, receives the words and writes them into the movement RAM. The list
// is framed either by a leading count word (END_MODE=0) or by a terminator
// word (END_MODE=1). A silent link triggers a timeout and a full re-request,
// up to MAX_RETRY times, before the block gives up in ERRO.
module recebe_movimentos_param #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 6,
  parameter logic [DATA_W-1:0] REQ_WORD    = 8'h52,
  parameter int                END_MODE    = 0,
  parameter logic [DATA_W-1:0] END_WORD    = 8'hFF,
  parameter int                TIMEOUT_CYC = 50_000_000,
  parameter int                MAX_RETRY   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              tx_pronto,
  input  logic              rx_valido,
  input  logic [DATA_W-1:0] rx_dado,
  output logic              tx_partida,
  output logic [DATA_W-1:0] tx_dado,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W:0]   num_movimentos,
  output logic              ocupado,
  output logic              pronto,
  output logic              erro,
  output logic [3:0]        db_estado
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // Header comparisons need room for both the received word and DEPTH.
  localparam int HDR_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARACAO = 4'd1,
    TRANSMITE  = 4'd2,
    ESPERA_CAB = 4'd3,
    RECEBE     = 4'd4,
    ARMAZENA   = 4'd5,
    ATUALIZA   = 4'd6,
    FIM        = 4'd7,
    ERRO       = 4'd8
  } estado_t;

  estado_t           estado, estado_prox;
  logic [CNT_W-1:0]  n_total;
  logic [TMR_W-1:0]  timer;
  logic [RTY_W-1:0]  rty_cnt;

  logic              limpa, carrega_n, carrega_dado;
  logic              inc_cnt, inc_addr, rty_inc, rty_limpa;
  logic              tmr_ativo, tmr_expira;
  logic [HDR_W-1:0]  cabecalho;
  logic [CNT_W-1:0]  cnt_prox;
  estado_t           destino_timeout;

  assign tx_dado    = REQ_WORD;
  assign tmr_ativo  = (estado == ESPERA_CAB) || (estado == RECEBE);
  assign tmr_expira = tmr_ativo && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign cabecalho  = HDR_W'(rx_dado);
  assign cnt_prox   = num_movimentos + CNT_W'(1);
  assign destino_timeout = (rty_cnt < RTY_W'(MAX_RETRY)) ? PREPARACAO : ERRO;

  // State register; reset aborts any transfer at once, so mem_we drops with it.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  // Next-state decode plus the per-state outputs and datapath controls.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    estado_prox  = estado;
    limpa        = 1'b0;
    carrega_n    = 1'b0;
    carrega_dado = 1'b0;
    inc_cnt      = 1'b0;
    inc_addr     = 1'b0;
    rty_inc      = 1'b0;
    rty_limpa    = 1'b0;
    tx_partida   = 1'b0;
    mem_we       = 1'b0;
    ocupado      = 1'b0;
    pronto       = 1'b0;
    erro         = 1'b0;
    db_estado    = estado;
    case (estado)
      INICIAL: begin
        rty_limpa = 1'b1;
        if (iniciar) estado_prox = PREPARACAO;
      end
      PREPARACAO: begin
        ocupado     = 1'b1;
        limpa       = 1'b1;
        tx_partida  = 1'b1;
        estado_prox = TRANSMITE;
      end
      TRANSMITE: begin
        ocupado = 1'b1;
        if (tx_pronto) estado_prox = (END_MODE == 0) ? ESPERA_CAB : RECEBE;
      end
      ESPERA_CAB: begin
        ocupado = 1'b1;
        if (rx_valido) begin
          // An incoming word beats a coinciding timeout.
          carrega_n = 1'b1;
          if (cabecalho == '0)                 estado_prox = FIM;
          else if (cabecalho > HDR_W'(DEPTH))  estado_prox = ERRO;
          else                                 estado_prox = RECEBE;
        end else if (tmr_expira) begin
          rty_inc     = (destino_timeout == PREPARACAO);
          estado_prox = destino_timeout;
        end
      end
      RECEBE: begin
        ocupado = 1'b1;
        if (rx_valido) begin
          carrega_dado = 1'b1;
          if (END_MODE != 0 && rx_dado == END_WORD) estado_prox = FIM;
          else                                      estado_prox = ARMAZENA;
        end else if (tmr_expira) begin
          rty_inc     = (destino_timeout == PREPARACAO);
          estado_prox = destino_timeout;
        end
      end
      ARMAZENA: begin
        ocupado     = 1'b1;
        mem_we      = 1'b1;
        estado_prox = ATUALIZA;
      end
      ATUALIZA: begin
        ocupado = 1'b1;
        inc_cnt = 1'b1;
        // The address only advances when another word is expected, so it
        // never wraps past DEPTH-1.
        if (END_MODE == 0 && cnt_prox == n_total) begin
          estado_prox = FIM;
        end else if (END_MODE != 0 && cnt_prox == CNT_W'(DEPTH)) begin
          estado_prox = ERRO;
        end else begin
          inc_addr    = 1'b1;
          estado_prox = RECEBE;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_prox = PREPARACAO;
      end
      ERRO: begin
        erro = 1'b1;
        if (iniciar) begin
          rty_limpa   = 1'b1;
          estado_prox = PREPARACAO;
        end
      end
      default: begin
        estado_prox = INICIAL;
        db_estado   = 4'hF;
      end
    endcase
  end

  // Address, count, header and word buffer; all cleared at each new request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr       <= '0;
      num_movimentos <= '0;
      mem_dado       <= '0;
      n_total        <= '0;
    end else if (limpa) begin
      mem_addr       <= '0;
      num_movimentos <= '0;
      mem_dado       <= '0;
      n_total        <= '0;
    end else begin
      if (carrega_n)    n_total        <= CNT_W'(rx_dado);
      if (carrega_dado) mem_dado       <= rx_dado;
      if (inc_cnt)      num_movimentos <= cnt_prox;
      if (inc_addr)     mem_addr       <= mem_addr + ADDR_W'(1);
    end
  end

  // Idle timer: counts only while waiting for a word, restarts on each word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       timer <= '0;
    else if (!tmr_ativo || rx_valido) timer <= '0;
    else                             timer <= timer + TMR_W'(1);
  end

  // Retry counter: bumped on each timeout re-request, cleared on a fresh start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          rty_cnt <= '0;
    else if (rty_limpa) rty_cnt <= '0;
    else if (rty_inc)   rty_cnt <= rty_cnt + RTY_W'(1);
  end

endmodule

// File: tb/tb_recebe_movimentos_param.sv
// Bench for recebe_movimentos_param: one instance per framing mode, both with
// a short timeout so the retry path is reachable in a few hundred cycles.
module tb_recebe_movimentos_param;

  localparam int TMO = 20;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       iniciar_v   [2];
  logic       tx_pronto_v [2];
  logic       rx_valido_v [2];
  logic [7:0] rx_dado_v   [2];
  logic       tx_partida_v[2];
  logic       mem_we_v    [2];
  logic       ocupado_v   [2];
  logic       pronto_v    [2];
  logic       erro_v      [2];
  logic [7:0] tx_dado_v   [2];
  logic [7:0] mem_dado_v  [2];
  logic [5:0] mem_addr_v  [2];
  logic [6:0] num_v       [2];
  logic [3:0] db_v        [2];

  recebe_movimentos_param #(.END_MODE(0), .TIMEOUT_CYC(TMO), .MAX_RETRY(2)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[0]), .tx_pronto(tx_pronto_v[0]),
    .rx_valido(rx_valido_v[0]), .rx_dado(rx_dado_v[0]), .tx_partida(tx_partida_v[0]),
    .tx_dado(tx_dado_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
    .mem_dado(mem_dado_v[0]), .num_movimentos(num_v[0]), .ocupado(ocupado_v[0]),
    .pronto(pronto_v[0]), .erro(erro_v[0]), .db_estado(db_v[0]));

  recebe_movimentos_param #(.END_MODE(1), .TIMEOUT_CYC(TMO), .MAX_RETRY(2)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[1]), .tx_pronto(tx_pronto_v[1]),
    .rx_valido(rx_valido_v[1]), .rx_dado(rx_dado_v[1]), .tx_partida(tx_partida_v[1]),
    .tx_dado(tx_dado_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
    .mem_dado(mem_dado_v[1]), .num_movimentos(num_v[1]), .ocupado(ocupado_v[1]),
    .pronto(pronto_v[1]), .erro(erro_v[1]), .db_estado(db_v[1]));

  int n_cmp  = 0;
  int n_fail = 0;
  int tx_cnt[2] = '{0, 0};
  int wr_cnt[2] = '{0, 0};

  // Pulse counters, sampled on the falling edge.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_partida_v[d]) tx_cnt[d]++;
      if (mem_we_v[d])     wr_cnt[d]++;
    end
  end

  typedef struct {
    int         d;
    int         n;
    logic [7:0] w [4];
    logic [3:0] we_mask;
    logic       exp_pronto;
    logic       exp_erro;
    int         exp_cnt;
    int         exp_wr;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(int d, int n, logic [7:0] w0, logic [7:0] w1,
                              logic [7:0] w2, logic [7:0] w3, logic [3:0] m,
                              logic p, logic e, int c, int wr);
    vec_t v;
    v.d = d; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.we_mask = m; v.exp_pronto = p; v.exp_erro = e; v.exp_cnt = c; v.exp_wr = wr;
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request sequence: iniciar pulse, then acknowledge the TX one cycle later.
  task automatic start_req(input int d);
    iniciar_v[d] = 1'b1;
    tick();
    iniciar_v[d] = 1'b0;
    tick();
    tx_pronto_v[d] = 1'b1;
    tick();
    tx_pronto_v[d] = 1'b0;
  endtask

  // One received word; the RAM write is expected in the following cycle.
  task automatic send_word(input int d, input logic [7:0] data, input logic exp_we,
                           input logic [5:0] exp_addr);
    rx_valido_v[d] = 1'b1;
    rx_dado_v[d]   = data;
    tick();
    rx_valido_v[d] = 1'b0;
    check($sformatf("we d%0d w%0h", d, data), mem_we_v[d], exp_we);
    if (exp_we) begin
      check($sformatf("addr d%0d w%0h", d, data), mem_addr_v[d], exp_addr);
      check($sformatf("data d%0d w%0h", d, data), mem_dado_v[d], data);
    end
    tick();
    tick();
  endtask

  task automatic wait_state(input int d, input logic [3:0] s, input int limit);
    for (int k = 0; k < limit && db_v[d] != s; k++) tick();
    check($sformatf("reach state %0d d%0d", s, d), db_v[d], s);
  endtask

  int tx0, wr0, a;

  initial begin
    vecs[0] = mk(0, 4, 8'h03, 8'h11, 8'h22, 8'h33, 4'b1110, 1, 0, 3, 3);
    vecs[1] = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 0, 0, 0);
    vecs[2] = mk(0, 1, 8'h41, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 1, 0, 0);
    vecs[3] = mk(0, 2, 8'h01, 8'hA5, 8'h00, 8'h00, 4'b0010, 1, 0, 1, 1);
    vecs[4] = mk(1, 3, 8'h05, 8'h07, 8'hFF, 8'h00, 4'b0011, 1, 0, 2, 2);
    vecs[5] = mk(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 0, 0, 0);
    vecs[6] = mk(1, 3, 8'h80, 8'h00, 8'hFF, 8'h00, 4'b0011, 1, 0, 2, 2);

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iniciar_v[d] = 0; tx_pronto_v[d] = 0; rx_valido_v[d] = 0; rx_dado_v[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst db d%0d", d), db_v[d], 4'd0);
      check($sformatf("rst tx_dado d%0d", d), tx_dado_v[d], 8'h52);
      check($sformatf("rst outs d%0d", d),
            {tx_partida_v[d], mem_we_v[d], ocupado_v[d], pronto_v[d], erro_v[d]}, 5'b0);
      check($sformatf("rst num d%0d", d), num_v[d], 7'd0);
      check($sformatf("rst addr/data d%0d", d), {mem_addr_v[d], mem_dado_v[d]}, 14'd0);
    end
    reset = 1'b0;
    tick();

    // Table-driven framing cases.
    for (int r = 0; r < 7; r++) begin
      tx0 = tx_cnt[vecs[r].d];
      wr0 = wr_cnt[vecs[r].d];
      start_req(vecs[r].d);
      a = 0;
      for (int i = 0; i < vecs[r].n; i++) begin
        send_word(vecs[r].d, vecs[r].w[i], vecs[r].we_mask[i], 6'(a));
        if (vecs[r].we_mask[i]) a++;
      end
      check($sformatf("v%0d pronto", r), pronto_v[vecs[r].d], vecs[r].exp_pronto);
      check($sformatf("v%0d erro", r), erro_v[vecs[r].d], vecs[r].exp_erro);
      check($sformatf("v%0d ocupado", r), ocupado_v[vecs[r].d], 1'b0);
      check($sformatf("v%0d num", r), num_v[vecs[r].d], vecs[r].exp_cnt);
      check($sformatf("v%0d writes", r), wr_cnt[vecs[r].d] - wr0, vecs[r].exp_wr);
      check($sformatf("v%0d tx pulses", r), tx_cnt[vecs[r].d] - tx0, 1);
    end

    // A word arriving in FIM is ignored.
    wr0 = wr_cnt[1];
    rx_valido_v[1] = 1'b1; rx_dado_v[1] = 8'h12;
    tick();
    rx_valido_v[1] = 1'b0;
    tick();
    check("fim drop state", db_v[1], 4'd7);
    check("fim drop num", num_v[1], 7'd2);
    check("fim drop writes", wr_cnt[1] - wr0, 0);

    // Header equal to DEPTH fills the whole RAM and ends in FIM.
    wr0 = wr_cnt[0];
    start_req(0);
    send_word(0, 8'h40, 1'b0, 6'd0);
    for (int i = 0; i < 64; i++) send_word(0, 8'(i) ^ 8'h5A, 1'b1, 6'(i));
    check("n64 pronto", pronto_v[0], 1'b1);
    check("n64 num", num_v[0], 7'd64);
    check("n64 writes", wr_cnt[0] - wr0, 64);
    check("n64 addr", mem_addr_v[0], 6'd63);

    // Terminator mode: 64 words without END_WORD overflow into ERRO.
    wr0 = wr_cnt[1];
    start_req(1);
    for (int i = 0; i < 64; i++) send_word(1, 8'(i), 1'b1, 6'(i));
    check("ovf erro", erro_v[1], 1'b1);
    check("ovf pronto", pronto_v[1], 1'b0);
    check("ovf num", num_v[1], 7'd64);
    check("ovf writes", wr_cnt[1] - wr0, 64);

    // Silent link: two re-requests, then ERRO.
    tx0 = tx_cnt[0];
    start_req(0);
    for (int k = 0; k < 2; k++) begin
      wait_state(0, 4'd2, 60);
      tx_pronto_v[0] = 1'b1;
      tick();
      tx_pronto_v[0] = 1'b0;
    end
    wait_state(0, 4'd8, 60);
    check("tmo tx pulses", tx_cnt[0] - tx0, 3);
    check("tmo erro/pronto", {erro_v[0], pronto_v[0]}, 2'b10);

    // Header arriving exactly on the expiry cycle is accepted, no retry.
    tx0 = tx_cnt[0];
    start_req(0);
    repeat (TMO - 1) tick();
    check("expiry still waiting", db_v[0], 4'd3);
    rx_valido_v[0] = 1'b1; rx_dado_v[0] = 8'h01;
    tick();
    rx_valido_v[0] = 1'b0;
    check("expiry word wins", db_v[0], 4'd4);
    check("expiry no retry", tx_cnt[0] - tx0, 1);
    send_word(0, 8'hC3, 1'b1, 6'd0);
    check("expiry pronto", pronto_v[0], 1'b1);
    check("expiry num", num_v[0], 7'd1);

    // Reset asserted while a write is in progress.
    start_req(0);
    send_word(0, 8'h02, 1'b0, 6'd0);
    send_word(0, 8'hAA, 1'b1, 6'd0);
    rx_valido_v[0] = 1'b1; rx_dado_v[0] = 8'hBB;
    tick();
    rx_valido_v[0] = 1'b0;
    check("pre-rst in ARMAZENA", {db_v[0], mem_we_v[0]}, {4'd5, 1'b1});
    check("pre-rst num", num_v[0], 7'd1);
    reset = 1'b1;
    #1;
    check("rst async we", mem_we_v[0], 1'b0);
    wr0 = wr_cnt[0];
    tick();
    check("rst db", db_v[0], 4'd0);
    check("rst we", mem_we_v[0], 1'b0);
    check("rst num", num_v[0], 7'd0);
    check("rst ocupado", ocupado_v[0], 1'b0);
    check("rst no write", wr_cnt[0] - wr0, 0);
    reset = 1'b0;
    tick();
    check("post-rst idle", db_v[0], 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
